// File: rtl/add_rs.sv
// -----------------------------------------------------------------------------
// add_rs : reservation station for the integer add/sub functional unit.
//
// Buffers renamed add/sub instructions in NUM_ENTRIES entries. Each entry
// snoops the common data bus for missing operands. The lowest-index ready
// entry is sent to the adder. Its tag is then held on tag_out until the CDB
// broadcasts that tag, and at that point the entry is freed.
//
// Parameters:
//   NUM_ENTRIES - number of station entries (1..8)
//   TAG_BASE    - tag owned by entry 0; entry i owns TAG_BASE+i.
//                 Tag 0 means "operand valid, no producer".
//
// Ports:
//   clk, reset              - clock; asynchronous active-high reset
//   issue_valid/ready/tag   - issue handshake; issue_tag is the tag of the
//                             lowest free entry (0 when full)
//   issue_isadd, issue_vj/vk, issue_qj/qk - instruction fields
//   cdb_valid/tag/data      - common data bus snoop
//   start                   - one-cycle dispatch pulse to the adder
//   src_a, src_b, isadd     - registered operands and op select to the adder
//   tag_out                 - tag of the in-flight entry
//
// Build option:
//   ADD_RS_BACK2BACK_EN - when defined, the edge that frees the in-flight
//                         entry can also dispatch the next ready entry.
//                         This removes the idle cycle between ops.
// -----------------------------------------------------------------------------
module add_rs #(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_BASE    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    output logic [3:0]  issue_tag,
    input  logic        issue_isadd,
    input  logic [31:0] issue_vj,
    input  logic [31:0] issue_vk,
    input  logic [3:0]  issue_qj,
    input  logic [3:0]  issue_qk,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    output logic        start,
    output logic [31:0] src_a,
    output logic [31:0] src_b,
    output logic        isadd,
    output logic [3:0]  tag_out
);

    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    // Entry storage
    logic        busy_reg [NUM_ENTRIES];
    logic        disp_reg [NUM_ENTRIES];
    logic        op_reg   [NUM_ENTRIES];
    logic [31:0] vj_reg   [NUM_ENTRIES];
    logic [31:0] vk_reg   [NUM_ENTRIES];
    logic [3:0]  qj_reg   [NUM_ENTRIES];
    logic [3:0]  qk_reg   [NUM_ENTRIES];

    logic [0:0]    state_reg;
    logic [IW-1:0] cur_idx_reg;   // entry currently in flight on the adder

    logic [3:0]             entry_tag [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] rdy;
    logic [NUM_ENTRIES-1:0] free_vec;

    logic          free_any;
    logic [IW-1:0] free_idx;
    logic          ready_any;
    logic [IW-1:0] sel_idx;
    logic          issue_fire;
    logic          free_now;
    logic          dispatch_now;
    logic          byp_j;
    logic          byp_k;

    // Readiness uses registered Q fields only. An operand captured on an edge
    // therefore makes the entry selectable from the following cycle.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign entry_tag[gi] = 4'(TAG_BASE + gi);
            assign rdy[gi]       = busy_reg[gi] && !disp_reg[gi] &&
                                   (qj_reg[gi] == 4'd0) && (qk_reg[gi] == 4'd0);
            assign free_vec[gi]  = !busy_reg[gi];
        end
    endgenerate

    // Lowest-index priority encoders. The loops scan downward, so the last
    // match written is the lowest index.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (free_vec[i]) free_idx = IW'(i);
            if (rdy[i])      sel_idx  = IW'(i);
        end
    end

    assign free_any    = |free_vec;
    assign ready_any   = |rdy;
    assign issue_ready = free_any;
    assign issue_tag   = free_any ? entry_tag[free_idx] : 4'd0;
    assign issue_fire  = issue_valid && free_any;

    assign byp_j = cdb_valid && (cdb_tag != 4'd0) && (issue_qj == cdb_tag);
    assign byp_k = cdb_valid && (cdb_tag != 4'd0) && (issue_qk == cdb_tag);

    assign free_now = (state_reg == ST_EXEC) && cdb_valid && (cdb_tag == tag_out);

    // The entry being freed is already marked dispatched, so it never shows
    // up in rdy. The back-to-back pick therefore excludes it automatically.
`ifdef ADD_RS_BACK2BACK_EN
    assign dispatch_now = ready_any && ((state_reg == ST_IDLE) || free_now);
`else
    assign dispatch_now = ready_any && (state_reg == ST_IDLE);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                busy_reg[i] <= 1'b0;
                disp_reg[i] <= 1'b0;
                op_reg[i]   <= 1'b0;
                vj_reg[i]   <= '0;
                vk_reg[i]   <= '0;
                qj_reg[i]   <= '0;
                qk_reg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (issue_fire && (free_idx == IW'(i))) begin
                    // A free slot cannot also be the one being freed, so
                    // issue and free never collide on the same entry.
                    busy_reg[i] <= 1'b1;
                    disp_reg[i] <= 1'b0;
                    op_reg[i]   <= issue_isadd;
                    vj_reg[i]   <= byp_j ? cdb_data : issue_vj;
                    vk_reg[i]   <= byp_k ? cdb_data : issue_vk;
                    qj_reg[i]   <= byp_j ? 4'd0 : issue_qj;
                    qk_reg[i]   <= byp_k ? 4'd0 : issue_qk;
                end else if (busy_reg[i]) begin
                    if (cdb_valid && (cdb_tag != 4'd0) && (qj_reg[i] == cdb_tag)) begin
                        vj_reg[i] <= cdb_data;
                        qj_reg[i] <= 4'd0;
                    end
                    if (cdb_valid && (cdb_tag != 4'd0) && (qk_reg[i] == cdb_tag)) begin
                        vk_reg[i] <= cdb_data;
                        qk_reg[i] <= 4'd0;
                    end
                    if (dispatch_now && (sel_idx == IW'(i))) begin
                        disp_reg[i] <= 1'b1;
                    end
                    if (free_now && (cur_idx_reg == IW'(i))) begin
                        busy_reg[i] <= 1'b0;
                        disp_reg[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Adder-side control. dispatch_now is only asserted in IDLE, or (with
    // back-to-back enabled) on the freeing edge. Either way the next state
    // is EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cur_idx_reg <= '0;
            start       <= 1'b0;
            src_a       <= '0;
            src_b       <= '0;
            isadd       <= 1'b0;
            tag_out     <= '0;
        end else begin
            start <= dispatch_now;
            if (dispatch_now) begin
                state_reg   <= ST_EXEC;
                cur_idx_reg <= sel_idx;
                src_a       <= vj_reg[sel_idx];
                src_b       <= vk_reg[sel_idx];
                isadd       <= op_reg[sel_idx];
                tag_out     <= entry_tag[sel_idx];
            end else if (free_now) begin
                state_reg <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_add_rs.sv
module tb_add_rs;

`ifdef ADD_RS_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_tag;
    logic        issue_isadd;
    logic [31:0] issue_vj, issue_vk;
    logic [3:0]  issue_qj, issue_qk;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        start;
    logic [31:0] src_a, src_b;
    logic        isadd;
    logic [3:0]  tag_out;

    add_rs #(.NUM_ENTRIES(3), .TAG_BASE(1)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_isadd(issue_isadd), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .start(start), .src_a(src_a), .src_b(src_b), .isadd(isadd), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   start_count = 0;

    // Scoreboard: every start pulse is matched against the next expected dispatch.
    always @(negedge clk) begin
        if (reset === 1'b0 && start === 1'b1) begin
            start_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start got tag=%0d a=%0h b=%0h op=%0b, no dispatch expected",
                         tag_out, src_a, src_b, isadd);
            end else begin
                mon_e = exp_q.pop_front();
                if (tag_out !== mon_e.tag || src_a !== mon_e.a || src_b !== mon_e.b || isadd !== mon_e.op) begin
                    errors++;
                    $display("FAIL dispatch got tag=%0d a=%0h b=%0h op=%0b exp tag=%0d a=%0h b=%0h op=%0b",
                             tag_out, src_a, src_b, isadd, mon_e.tag, mon_e.a, mon_e.b, mon_e.op);
                end else begin
                    $display("dispatch tag=%0d a=%0h b=%0h op=%0b", tag_out, src_a, src_b, isadd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [3:0] qj, input logic [3:0] qk);
        issue_valid = 1'b1;
        issue_isadd = op;
        issue_vj    = vj;
        issue_vk    = vk;
        issue_qj    = qj;
        issue_qk    = qk;
    endtask

    task automatic push_exp(input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b,
                            input logic op);
        exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.op = op;
        exp_q.push_back(e);
    endtask

    task automatic cdb_pulse(input logic [3:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
        step();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL %s got start=%b exp 1 within 20 cycles", nm, start);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({start, isadd, tag_out} !== 6'd0 || src_a !== 32'd0 || src_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got start=%b isadd=%b tag=%0d a=%0h b=%0h exp all 0",
                     start, isadd, tag_out, src_a, src_b);
        end
        checks++;
        if (issue_ready !== 1'b1 || issue_tag !== 4'd1) begin
            errors++;
            $display("FAIL reset_issue got ready=%b tag=%0d exp ready=1 tag=1", issue_ready, issue_tag);
        end
        reset = 1'b0;
        step();
        $display("reset done");
    endtask

    task automatic test_basic();
        set_issue(1'b1, 32'd5, 32'd7, 4'd0, 4'd0);
        #1;
        checks++;
        if (issue_tag !== 4'd1 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_issue_tag got tag=%0d ready=%b exp tag=1 ready=1", issue_tag, issue_ready);
        end
        push_exp(4'd1, 32'd5, 32'd7, 1'b1);
        step();
        issue_valid = 1'b0;
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency_early got start=%b exp 0", start);
        end
        step();
        checks++;
        if (start !== 1'b1 || tag_out !== 4'd1) begin
            errors++;
            $display("FAIL basic_start got start=%b tag=%0d exp start=1 tag=1", start, tag_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (start !== 1'b0 || tag_out !== 4'd1 || issue_tag !== 4'd2) begin
                errors++;
                $display("FAIL basic_hold got start=%b tag_out=%0d issue_tag=%0d exp 0/1/2",
                         start, tag_out, issue_tag);
            end
        end
        cdb_pulse(4'd1, 32'd12);
        checks++;
        if (issue_ready !== 1'b1 || issue_tag !== 4'd1) begin
            errors++;
            $display("FAIL basic_free got ready=%b tag=%0d exp ready=1 tag=1", issue_ready, issue_tag);
        end
        step();
    endtask

    task automatic test_snoop();
        set_issue(1'b0, 32'd0, 32'd3, 4'd4, 4'd0);
        push_exp(4'd1, 32'd10, 32'd3, 1'b0);
        step();
        issue_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (start !== 1'b0) begin
                errors++;
                $display("FAIL snoop_wait got start=%b exp 0", start);
            end
        end
        cdb_pulse(4'd4, 32'd10);
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL snoop_capture_edge got start=%b exp 0", start);
        end
        step();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL snoop_start got start=%b exp 1", start);
        end
        step();
        cdb_pulse(4'd1, 32'd0);
        step();
    endtask

    task automatic test_bypass();
        set_issue(1'b1, 32'd0, 32'd1, 4'd5, 4'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_data  = 32'h0000DEAD;
        push_exp(4'd1, 32'h0000DEAD, 32'd1, 1'b1);
        step();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        step();
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL bypass_start got start=%b exp 1", start);
        end
        step();
        cdb_pulse(4'd1, 32'd0);
        step();
    endtask

    task automatic test_full();
        set_issue(1'b1, 32'd1, 32'd2, 4'd0, 4'd0);
        push_exp(4'd1, 32'd1, 32'd2, 1'b1);
        step();
        set_issue(1'b0, 32'd3, 32'd4, 4'd0, 4'd0);
        push_exp(4'd2, 32'd3, 32'd4, 1'b0);
        step();
        set_issue(1'b1, 32'd5, 32'd6, 4'd0, 4'd0);
        push_exp(4'd3, 32'd5, 32'd6, 1'b1);
        step();
        issue_valid = 1'b0;
        checks++;
        if (issue_ready !== 1'b0 || issue_tag !== 4'd0) begin
            errors++;
            $display("FAIL full_ready got ready=%b tag=%0d exp ready=0 tag=0", issue_ready, issue_tag);
        end
        set_issue(1'b0, 32'hBAD, 32'hBAD, 4'd0, 4'd0);
        step();
        issue_valid = 1'b0;
        checks++;
        if (issue_ready !== 1'b0 || tag_out !== 4'd1) begin
            errors++;
            $display("FAIL full_reject got ready=%b tag_out=%0d exp ready=0 tag_out=1", issue_ready, tag_out);
        end
        for (int k = 1; k <= 3; k++) begin
            cdb_pulse(4'(k), 32'd0);
            if (k < 3) begin
                if (B2B) begin
                    checks++;
                    if (start !== 1'b1 || tag_out !== 4'(k + 1)) begin
                        errors++;
                        $display("FAIL full_b2b got start=%b tag=%0d exp start=1 tag=%0d", start, tag_out, k + 1);
                    end
                end else begin
                    checks++;
                    if (start !== 1'b0) begin
                        errors++;
                        $display("FAIL full_gap got start=%b exp 0", start);
                    end
                    step();
                    checks++;
                    if (start !== 1'b1 || tag_out !== 4'(k + 1)) begin
                        errors++;
                        $display("FAIL full_next got start=%b tag=%0d exp start=1 tag=%0d", start, tag_out, k + 1);
                    end
                end
                step();
            end else begin
                checks++;
                if (start !== 1'b0) begin
                    errors++;
                    $display("FAIL full_drain got start=%b exp 0", start);
                end
            end
        end
        step();
        checks++;
        if (issue_ready !== 1'b1 || issue_tag !== 4'd1) begin
            errors++;
            $display("FAIL full_empty got ready=%b tag=%0d exp ready=1 tag=1", issue_ready, issue_tag);
        end
    endtask

    task automatic test_unrelated();
        set_issue(1'b1, 32'd0, 32'h11, 4'd9, 4'd0);   // tag 1, waits on 9
        step();
        set_issue(1'b0, 32'h20, 32'h21, 4'd0, 4'd0);  // tag 2, ready
        push_exp(4'd2, 32'h20, 32'h21, 1'b0);
        step();
        set_issue(1'b1, 32'h30, 32'd0, 4'd0, 4'd7);   // tag 3, waits on 7
        push_exp(4'd3, 32'h30, 32'h77, 1'b1);
        push_exp(4'd1, 32'h99, 32'h11, 1'b1);
        step();
        issue_valid = 1'b0;
        checks++;
        if (start !== 1'b1 || tag_out !== 4'd2) begin
            errors++;
            $display("FAIL unrel_dispatch got start=%b tag=%0d exp start=1 tag=2", start, tag_out);
        end
        cdb_pulse(4'd7, 32'h77);
        checks++;
        if (tag_out !== 4'd2 || start !== 1'b0 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL unrel_hold got tag=%0d start=%b ready=%b exp tag=2 start=0 ready=0",
                     tag_out, start, issue_ready);
        end
        step();
        cdb_pulse(4'd2, 32'd0);
        wait_start("unrel_wait_tag3");
        checks++;
        if (tag_out !== 4'd3) begin
            errors++;
            $display("FAIL unrel_tag3 got tag=%0d exp 3", tag_out);
        end
        step();
        cdb_pulse(4'd9, 32'h99);
        checks++;
        if (tag_out !== 4'd3) begin
            errors++;
            $display("FAIL unrel_hold3 got tag=%0d exp 3", tag_out);
        end
        cdb_pulse(4'd3, 32'd0);
        wait_start("unrel_wait_tag1");
        checks++;
        if (tag_out !== 4'd1) begin
            errors++;
            $display("FAIL unrel_tag1 got tag=%0d exp 1", tag_out);
        end
        step();
        cdb_pulse(4'd1, 32'd0);
        step();
    endtask

    task automatic test_reset_mid();
        int snap;
        set_issue(1'b1, 32'h40, 32'h41, 4'd0, 4'd0);
        push_exp(4'd1, 32'h40, 32'h41, 1'b1);
        step();
        set_issue(1'b0, 32'h50, 32'h51, 4'd0, 4'd0);
        step();
        issue_valid = 1'b0;
        step();
        checks++;
        if (tag_out !== 4'd1 || issue_tag !== 4'd3) begin
            errors++;
            $display("FAIL rstmid_pre got tag_out=%0d issue_tag=%0d exp 1/3", tag_out, issue_tag);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0 || tag_out !== 4'd0 || issue_ready !== 1'b1 || issue_tag !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_async got start=%b tag_out=%0d ready=%b issue_tag=%0d exp 0/0/1/1",
                     start, tag_out, issue_ready, issue_tag);
        end
        step();
        reset = 1'b0;
        snap = start_count;
        repeat (10) step();
        checks++;
        if (start_count !== snap) begin
            errors++;
            $display("FAIL rstmid_no_start got %0d starts exp 0", start_count - snap);
        end
    endtask

    initial begin
        reset       = 1'b1;
        issue_valid = 1'b0;
        issue_isadd = 1'b0;
        issue_vj    = '0;
        issue_vk    = '0;
        issue_qj    = '0;
        issue_qk    = '0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        cdb_data    = '0;

        test_reset();
        test_basic();
        test_snoop();
        test_bypass();
        test_full();
        test_unrelated();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
